program_memory_block_master: RTL and testbench

//  Avalon-MM master driving the single-port program/data on-chip RAM slave (32b, word-addressed,

---
 rtl/program_memory_block_master.sv | 205 ++++++++++++++++++++
 tb/tb_program_memory_block_master.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_block_master.sv
// rtl/program_memory_block_master.sv - Avalon-MM block copy master between a valid/ready stream and on-chip RAM
//
// Purpose: copies `length` words starting at `base_addr` either from the input
// stream into RAM (write_mode=1) or from RAM out to the output stream
// (write_mode=0). Read data passes through a small skid FIFO so that the
// consumer can apply backpressure without losing words.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start, write_mode,
//   base_addr, length           command, sampled when start is seen in IDLE
//   busy, done, err             status; done/err are single-cycle pulses
//   in_data/in_valid/in_ready   write-mode input stream
//   out_data/out_valid/out_ready read-mode output stream (FIFO head)
//   m_*                         Avalon-MM master to the RAM slave
module program_memory_block_master #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 37500,
    parameter int RD_LAT = 1,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              write_mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic [31:0]       m_readdata
);
    localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W = $clog2(FIFO_D) + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WRITE, S_READ, S_DRAIN, S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              wmode_q, wmode_d;
    logic              rej_q, rej_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [31:0]       fifo_mem_q [FIFO_D];

    logic              wr_acc;
    logic              issue;
    logic              push;
    logic              pop;
    logic              credit_ok;
    logic              range_bad;
    logic [ADDR_W:0]   end_addr;
    logic [SUM_W-1:0]  used;

    // Words already committed to the FIFO plus reads still in the slave
    // pipeline; issuing only while this is below FIFO_D means every
    // returning word is guaranteed a free FIFO slot.
    assign used      = SUM_W'(fcnt_q) + SUM_W'(inflight_q);
    assign credit_ok = used < SUM_W'(FIFO_D);

    assign wr_acc = (state_q == S_WRITE) && in_valid;
    assign issue  = (state_q == S_READ) && (rem_q != '0) && credit_ok;
    assign push   = tag_q[RD_LAT-1];
    assign pop    = (fcnt_q != '0) && out_ready;

    // One extra bit so base+len cannot wrap before the comparison.
    assign end_addr  = {1'b0, ptr_q} + {1'b0, rem_q};
    assign range_bad = end_addr > (ADDR_W+1)'(DEPTH);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            wmode_q    <= 1'b0;
            rej_q      <= 1'b0;
            tag_q      <= '0;
            inflight_q <= '0;
            fcnt_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            wmode_q    <= wmode_d;
            rej_q      <= rej_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            fcnt_q     <= fcnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // FIFO storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= m_readdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        wmode_d = wmode_q;
        rej_d   = rej_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                    ptr_d   = base_addr;
                    rem_d   = length;
                    wmode_d = write_mode;
                    rej_d   = 1'b0;
                end
            end
            S_CHECK: begin
                if (rem_q == '0) begin
                    state_d = S_FINISH;
                end else if (range_bad) begin
                    state_d = S_FINISH;
                    rej_d   = 1'b1;
                end else begin
                    state_d = wmode_q ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (wr_acc) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight_q == '0) && (fcnt_q == '0)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Read pipeline tags and skid FIFO bookkeeping
    always_comb begin
        // Each issue enters the tag line; the bit leaving the top marks the
        // cycle in which m_readdata holds that word.
        tag_d      = RD_LAT'({tag_q, issue});
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
        fcnt_d     = fcnt_q + CNT_W'(push) - CNT_W'(pop);
        wptr_d     = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + PTR_W'(1) : rptr_q;
    end

    // Outputs
    always_comb begin
        busy         = (state_q == S_CHECK) || (state_q == S_WRITE) ||
                       (state_q == S_READ)  || (state_q == S_DRAIN);
        done         = (state_q == S_FINISH);
        err          = (state_q == S_FINISH) && rej_q;
        in_ready     = (state_q == S_WRITE);
        m_chipselect = wr_acc || issue;
        m_write      = wr_acc;
        m_address    = (wr_acc || issue) ? ptr_q : '0;
        m_writedata  = wr_acc ? in_data : '0;
        m_byteenable = 4'hF;
        m_clken      = 1'b1;
        out_valid    = (fcnt_q != '0);
        out_data     = fifo_mem_q[rptr_q];
    end
endmodule

// File: tb/tb_program_memory_block_master.sv
// tb/tb_program_memory_block_master.sv - self-checking bench for program_memory_block_master
module tb_program_memory_block_master;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 37500;
    localparam int RD_LAT = 1;
    localparam int FIFO_D = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              write_mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              busy, done, err;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect, m_write, m_clken;
    logic [3:0]        m_byteenable;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram   [0:65535];
    logic [31:0] model [0:65535];
    logic [31:0] rd_pipe [RD_LAT];

    always #5 clk = ~clk;

    program_memory_block_master #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .write_mode(write_mode),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .err(err), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_clken(m_clken), .m_readdata(m_readdata)
    );

    // RAM slave: fixed RD_LAT read latency, non-read cycles return a marker.
    always @(posedge clk) begin
        if (m_chipselect && m_write) ram[m_address] <= m_writedata;
        rd_pipe[0] <= (m_chipselect && !m_write) ? ram[m_address] : 32'hDEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign m_readdata = rd_pipe[RD_LAT-1];

    task automatic idle_inputs();
        start = 0; write_mode = 0; base_addr = '0; length = '0;
        in_data = '0; in_valid = 0; out_ready = 0;
    endtask

    task automatic preload(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            logic [31:0] v;
            v = $urandom;
            ram[base+i] = v;
            model[base+i] = v;
        end
    endtask

    // Write transfer; vmode 0 = in_valid always high, 1 = random gaps.
    task automatic do_write(input int base, input int len, input int vmode);
        int acc = 0, last_acc = -10, k;
        bit seen = 0;
        logic [31:0] word;
        @(negedge clk);
        start = 1; write_mode = 1; base_addr = ADDR_W'(base); length = ADDR_W'(len);
        for (k = 1; k <= 20 + len * 6; k++) begin
            @(negedge clk);
            start = 0;
            word = $urandom;
            in_data = word;
            in_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            total++;
            if (in_ready !== ((k >= 2) && (acc < len))) begin
                bad++; $display("FAIL wr_in_ready k=%0d got=%b want=%b", k, in_ready, (k >= 2) && (acc < len));
            end
            if (in_valid && (k >= 2) && (acc < len)) begin
                total++;
                if (!(m_chipselect === 1 && m_write === 1 && m_address === ADDR_W'(base + acc) && m_writedata === word)) begin
                    bad++; $display("FAIL wr_bus k=%0d cs=%b we=%b addr=%h want_addr=%h data=%h want=%h",
                        k, m_chipselect, m_write, m_address, ADDR_W'(base + acc), m_writedata, word);
                end
                model[base+acc] = word;
                acc++;
                last_acc = k;
            end else begin
                total++;
                if (m_chipselect !== 0) begin
                    bad++; $display("FAIL wr_idle_bus k=%0d cs=%b want=0", k, m_chipselect);
                end
            end
            total++;
            if (done === 1) begin
                if (!(k == last_acc + 1 && acc == len && busy === 0 && err === 0)) begin
                    bad++; $display("FAIL wr_done k=%0d want_k=%0d acc=%0d len=%0d busy=%b err=%b", k, last_acc + 1, acc, len, busy, err);
                end
                seen = 1;
                break;
            end else if (busy !== 1) begin
                bad++; $display("FAIL wr_busy k=%0d busy=%b want=1", k, busy);
            end
        end
        in_valid = 0;
        if (!seen) begin
            total++; bad++; $display("FAIL wr_timeout base=%0d len=%0d got=no_done want=done", base, len);
        end
        for (int i = 0; i < len; i++) begin
            total++;
            if (ram[base+i] !== model[base+i]) begin
                bad++; $display("FAIL wr_ram addr=%0d got=%h want=%h", base + i, ram[base+i], model[base+i]);
            end
        end
    endtask

    // Read transfer; rmode 0 = out_ready high, 1 = pattern 1,0,0,1, 2 = random.
    // restart_at > 0 pulses a second (write) start at that cycle, which must be ignored.
    task automatic do_read(input int base, input int len, input int rmode, input int restart_at);
        int issued = 0, pops = 0, arrived = 0, k;
        int first_iss = -1, first_pop = -1, last_pop = -1;
        int arr_q[$];
        bit seen = 0, prev_hold = 0, exp_iss;
        logic [31:0] prev_data = '0;
        int outstanding, avail;
        @(negedge clk);
        start = 1; write_mode = 0; base_addr = ADDR_W'(base); length = ADDR_W'(len); out_ready = 0;
        for (k = 1; k <= 40 + len * 8; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            write_mode = (k == restart_at);
            case (rmode)
                0:       out_ready = 1;
                1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
                default: out_ready = $urandom_range(0, 1);
            endcase
            #1;
            outstanding = issued - pops;
            exp_iss = (k >= 2) && (issued < len) && (outstanding < FIFO_D);
            total++;
            if (m_chipselect !== exp_iss || m_write !== 0) begin
                bad++; $display("FAIL rd_issue k=%0d cs=%b want=%b we=%b out=%0d", k, m_chipselect, exp_iss, m_write, outstanding);
            end
            if (exp_iss) begin
                total++;
                if (m_address !== ADDR_W'(base + issued)) begin
                    bad++; $display("FAIL rd_addr k=%0d got=%h want=%h", k, m_address, ADDR_W'(base + issued));
                end
                if (first_iss < 0) first_iss = k;
                issued++;
                arr_q.push_back(k + RD_LAT + 1);
            end
            while (arrived < arr_q.size() && arr_q[arrived] <= k) arrived++;
            avail = arrived - pops;
            total++;
            if (out_valid !== (avail > 0)) begin
                bad++; $display("FAIL rd_out_valid k=%0d got=%b want=%b", k, out_valid, avail > 0);
            end
            if (prev_hold) begin
                total++;
                if (out_data !== prev_data) begin
                    bad++; $display("FAIL rd_stable k=%0d got=%h want=%h", k, out_data, prev_data);
                end
            end
            if (avail > 0 && out_ready) begin
                total++;
                if (out_data !== model[base+pops]) begin
                    bad++; $display("FAIL rd_data idx=%0d got=%h want=%h", pops, out_data, model[base+pops]);
                end
                if (first_pop < 0) first_pop = k;
                last_pop = k;
                pops++;
            end
            prev_hold = (avail > 0) && !out_ready;
            prev_data = out_data;
            total++;
            if (done === 1) begin
                if (!(pops == len && k == last_pop + 2 && busy === 0 && err === 0)) begin
                    bad++; $display("FAIL rd_done k=%0d want_k=%0d pops=%0d len=%0d busy=%b err=%b", k, last_pop + 2, pops, len, busy, err);
                end
                if (rmode == 0) begin
                    total++;
                    if (first_pop - first_iss != RD_LAT + 1 || last_pop - first_pop != len - 1) begin
                        bad++; $display("FAIL rd_rate fill=%0d want=%0d span=%0d want=%0d", first_pop - first_iss, RD_LAT + 1, last_pop - first_pop, len - 1);
                    end
                end
                seen = 1;
                break;
            end else if (busy !== 1) begin
                bad++; $display("FAIL rd_busy k=%0d busy=%b want=1", k, busy);
            end
        end
        start = 0; write_mode = 0; out_ready = 0;
        if (!seen) begin
            total++; bad++; $display("FAIL rd_timeout base=%0d len=%0d got=no_done want=done", base, len);
        end
    endtask

    // Start that must finish at cycle 2 with no bus activity.
    task automatic do_reject(input int base, input int len, input logic exp_err);
        bit seen = 0;
        @(negedge clk);
        start = 1; write_mode = $urandom_range(0, 1); base_addr = ADDR_W'(base); length = ADDR_W'(len);
        in_valid = 1; out_ready = 1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 0;
            #1;
            total++;
            if (m_chipselect !== 0 || in_ready !== 0 || out_valid !== 0) begin
                bad++; $display("FAIL rej_bus k=%0d cs=%b in_ready=%b out_valid=%b want=0", k, m_chipselect, in_ready, out_valid);
            end
            total++;
            if (done === 1) begin
                if (!(k == 2 && err === exp_err && busy === 0)) begin
                    bad++; $display("FAIL rej_done k=%0d want_k=2 err=%b want=%b busy=%b", k, err, exp_err, busy);
                end
                seen = 1;
                break;
            end else if (err !== 0) begin
                bad++; $display("FAIL rej_err_early k=%0d err=%b want=0", k, err);
            end
        end
        in_valid = 0; out_ready = 0;
        if (!seen) begin
            total++; bad++; $display("FAIL rej_timeout got=no_done want=done");
        end
    endtask

    task automatic check_quiet(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            #1;
            total++;
            if (done !== 0 || busy !== 0 || m_chipselect !== 0) begin
                bad++; $display("FAIL quiet k=%0d done=%b busy=%b cs=%b want=0", k, done, busy, m_chipselect);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if ({busy, done, err, in_ready, out_valid, m_chipselect, m_write} !== 7'b0 ||
            m_address !== '0 || m_clken !== 1'b1 || m_byteenable !== 4'hF) begin
            bad++; $display("FAIL %s flags=%b want=0000000 addr=%h want=0 clken=%b want=1 be=%h want=f",
                tag, {busy, done, err, in_ready, out_valid, m_chipselect, m_write}, m_address, m_clken, m_byteenable);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset_state");
        reset = 0;
    endtask

    task automatic test_write();
        do_write(16, 4, 0);
        do_write(300, 9, 1);
    endtask

    task automatic test_read();
        preload(32, 8);
        do_read(32, 8, 0, 0);
    endtask

    task automatic test_backpressure();
        preload(64, 12);
        do_read(64, 12, 1, 0);
        preload(128, 10);
        do_read(128, 10, 2, 0);
    endtask

    task automatic test_range();
        do_reject(37496, 5, 1'b1);
        do_reject(65535, 2, 1'b1);
        do_write(37496, 4, 0);
        preload(37490, 10);
        do_read(37490, 10, 2, 0);
    endtask

    task automatic test_len0_busy();
        do_reject(100, 0, 1'b0);
        check_quiet(3);
        preload(200, 8);
        do_read(200, 8, 0, 3);
        check_quiet(6);
    endtask

    task automatic test_reset_mid();
        preload(32, 8);
        @(negedge clk);
        start = 1; write_mode = 0; base_addr = ADDR_W'(32); length = ADDR_W'(8); out_ready = 0;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        #1;
        check_reset_values("reset_mid");
        reset = 0;
        check_quiet(5);
        test_read();
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int len, base;
            len  = $urandom_range(1, 24);
            base = (t == 5) ? DEPTH - len : $urandom_range(0, DEPTH - len);
            do_write(base, len, 1);
            do_read(base, len, 2, 0);
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_range();
        test_len0_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
